// File: rtl/axil_lsu_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axil_lsu_master_if
// Description : AXI4-Lite bus bundle between the LSU master and a slave.
//               The master modport drives AR/AW/W payloads plus RREADY/BREADY.
//               The slave modport drives the ready signals and the R/B
//               channels.
// Signals     : araddr/arvalid/arready          read address channel
//               rdata/rresp/rvalid/rready       read data channel
//               awaddr/awvalid/awready          write address channel
//               wdata/wstrb/wvalid/wready       write data channel
//               bresp/bvalid/bready             write response channel
// Revision    : 1.0 - initial release
// ============================================================================
interface axil_lsu_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface
`default_nettype wire

// File: rtl/axil_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_lsu_master
// Description : AXI4-Lite initiator for the LSU/IFU stage. Turns one core
//               load/store request at a time into an AR/R or AW/W/B
//               transaction and returns the result on a valid/ready
//               response port.
// Ports       : clk, rst_n       clock, synchronous active-low reset
//               req_*            core request (valid/ready, we, addr, wdata, wstrb)
//               rsp_*            core response (valid/ready, rdata, err)
//               axi              AXI4-Lite master modport (axil_lsu_master_if)
// Options     : AXIL_MST_TIMEOUT_EN - abort a bus wait after TIMEOUT_CYCLES
//               cycles and answer with rsp_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_lsu_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   input  wire logic                req_valid,
   output logic                     req_ready,
   input  wire logic                req_we,
   input  wire logic [ADDR_W-1:0]   req_addr,
   input  wire logic [DATA_W-1:0]   req_wdata,
   input  wire logic [DATA_W/8-1:0] req_wstrb,
   output logic                     rsp_valid,
   input  wire logic                rsp_ready,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   axil_lsu_master_if.master        axi
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_D = 3'd2,
      S_WR_A = 3'd3,
      S_WR_B = 3'd4,
      S_RSP  = 3'd5
   } state_t;

   state_t r_state;
   logic   r_aw_done;
   logic   r_w_done;

   logic   w_aw_hs;
   logic   w_w_hs;
   logic   w_aw_done_nxt;
   logic   w_w_done_nxt;

   assign req_ready     = (r_state == S_IDLE);
   assign w_aw_hs       = axi.awvalid & axi.awready;
   assign w_w_hs        = axi.wvalid  & axi.wready;
   // Completion including a handshake happening on this very edge, so a
   // simultaneous AW+W handshake moves straight on to WR_B.
   assign w_aw_done_nxt = r_aw_done | w_aw_hs;
   assign w_w_done_nxt  = r_w_done  | w_w_hs;

`ifdef AXIL_MST_TIMEOUT_EN
   localparam int                c_tmo_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

   logic [c_tmo_w-1:0] r_tmo_cnt;
   logic               w_waiting;

   assign w_waiting = (r_state == S_RD_A) || (r_state == S_RD_D) ||
                      (r_state == S_WR_A) || (r_state == S_WR_B);
`else
   logic w_unused_tmo_param;
   assign w_unused_tmo_param = |TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_aw_done     <= 1'b0;
         r_w_done      <= 1'b0;
         axi.araddr    <= '0;
         axi.arvalid   <= 1'b0;
         axi.rready    <= 1'b0;
         axi.awaddr    <= '0;
         axi.awvalid   <= 1'b0;
         axi.wdata     <= '0;
         axi.wstrb     <= '0;
         axi.wvalid    <= 1'b0;
         axi.bready    <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
`ifdef AXIL_MST_TIMEOUT_EN
         r_tmo_cnt     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
`ifdef AXIL_MST_TIMEOUT_EN
                  r_tmo_cnt <= '0;
`endif
                  if (req_we) begin
                     axi.awaddr  <= req_addr;
                     axi.wdata   <= req_wdata;
                     axi.wstrb   <= req_wstrb;
                     axi.awvalid <= 1'b1;
                     axi.wvalid  <= 1'b1;
                     r_aw_done   <= 1'b0;
                     r_w_done    <= 1'b0;
                     r_state     <= S_WR_A;
                  end else begin
                     axi.araddr  <= req_addr;
                     axi.arvalid <= 1'b1;
                     r_state     <= S_RD_A;
                  end
               end
            end
            S_RD_A: begin
               if (axi.arready) begin
                  axi.arvalid <= 1'b0;
                  axi.rready  <= 1'b1;
                  r_state     <= S_RD_D;
               end
            end
            S_RD_D: begin
               if (axi.rvalid) begin
                  axi.rready <= 1'b0;
                  rsp_rdata  <= axi.rdata;
                  rsp_err    <= (axi.rresp != 2'b00);
                  rsp_valid  <= 1'b1;
                  r_state    <= S_RSP;
               end
            end
            S_WR_A: begin
               if (w_aw_hs) axi.awvalid <= 1'b0;
               if (w_w_hs)  axi.wvalid  <= 1'b0;
               r_aw_done <= w_aw_done_nxt;
               r_w_done  <= w_w_done_nxt;
               if (w_aw_done_nxt && w_w_done_nxt) begin
                  axi.bready <= 1'b1;
                  r_state    <= S_WR_B;
               end
            end
            S_WR_B: begin
               if (axi.bvalid) begin
                  axi.bready <= 1'b0;
                  rsp_rdata  <= '0;
                  rsp_err    <= (axi.bresp != 2'b00);
                  rsp_valid  <= 1'b1;
                  r_state    <= S_RSP;
               end
            end
            S_RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

`ifdef AXIL_MST_TIMEOUT_EN
         // Placed after the case so an expiring wait overrides any normal
         // progress scheduled on the same edge.
         if (w_waiting) begin
            if (r_tmo_cnt == c_tmo_last) begin
               axi.arvalid <= 1'b0;
               axi.rready  <= 1'b0;
               axi.awvalid <= 1'b0;
               axi.wvalid  <= 1'b0;
               axi.bready  <= 1'b0;
               rsp_rdata   <= '0;
               rsp_err     <= 1'b1;
               rsp_valid   <= 1'b1;
               r_state     <= S_RSP;
            end else begin
               r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axil_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_lsu_master
// Description : Self-checking bench for axil_lsu_master. A transaction-level
//               slave/core model issues directed and random loads/stores,
//               with random channel delays, and compares bus payloads and
//               core responses against values derived from the request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_lsu_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_errors = 0;

   axil_lsu_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   axil_lsu_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(255)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .axi       (axi)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_slave();
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bvalid  = 1'b0;
   endtask

   // One complete transaction. Delays count cycles of valid seen before the
   // slave (or core) answers; the expected response follows directly from
   // the request kind and the slave's answer.
   task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, input logic [31:0] rd, input logic [1:0] resp,
                          input int ar_d, input int r_d, input int aw_d, input int w_d,
                          input int b_d, input int rs_d);
      logic [31:0] exp_rdata;
      logic        exp_err;
      bit ar_ok = 0, r_ok = 0, aw_ok = 0, w_ok = 0, b_ok = 0, done = 0, aw_hs, w_hs;
      int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0, s_c = 0, cyc = 0;
      exp_rdata = we ? 32'h0 : rd;
      exp_err   = (resp != 2'b00);

      @(negedge clk);
      check_val("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
      @(negedge clk);
      // Scramble the request fields to show the DUT latched them.
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_wstrb = 4'($urandom);
      check_val("req_ready_busy", req_ready, 0);

      while (!done && cyc < 500) begin
         if (!we && !r_ok) begin
            check_val("wr_quiet_in_rd", {axi.awvalid, axi.wvalid, axi.bready}, 0);
            check_val("rsp_early", rsp_valid, 0);
            if (!ar_ok) begin
               check_val("arvalid", axi.arvalid, 1);
               check_val("araddr", axi.araddr, addr);
               check_val("rready_early", axi.rready, 0);
               axi.arready = (ar_c >= ar_d); ar_c++;
               if (axi.arvalid && axi.arready) ar_ok = 1;
            end else begin
               axi.arready = 1'b0;
               check_val("arvalid_drop", axi.arvalid, 0);
               check_val("rready", axi.rready, 1);
               axi.rvalid = (r_c >= r_d); r_c++;
               axi.rdata  = axi.rvalid ? rd : $urandom;
               axi.rresp  = axi.rvalid ? resp : 2'($urandom);
               if (axi.rvalid && axi.rready) r_ok = 1;
            end
         end else if (we && !b_ok) begin
            check_val("rd_quiet_in_wr", {axi.arvalid, axi.rready}, 0);
            check_val("rsp_early", rsp_valid, 0);
            if (!(aw_ok && w_ok)) begin
               aw_hs = 0; w_hs = 0;
               check_val("bready_early", axi.bready, 0);
               if (!aw_ok) begin
                  check_val("awvalid", axi.awvalid, 1);
                  check_val("awaddr", axi.awaddr, addr);
                  axi.awready = (aw_c >= aw_d); aw_c++;
                  aw_hs = axi.awvalid && axi.awready;
               end else begin
                  check_val("awvalid_drop", axi.awvalid, 0);
                  axi.awready = 1'b0;
               end
               if (!w_ok) begin
                  check_val("wvalid", axi.wvalid, 1);
                  check_val("wdata", axi.wdata, wd);
                  check_val("wstrb", axi.wstrb, strb);
                  axi.wready = (w_c >= w_d); w_c++;
                  w_hs = axi.wvalid && axi.wready;
               end else begin
                  check_val("wvalid_drop", axi.wvalid, 0);
                  axi.wready = 1'b0;
               end
               aw_ok = aw_ok | aw_hs;
               w_ok  = w_ok | w_hs;
            end else begin
               axi.awready = 1'b0; axi.wready = 1'b0;
               check_val("aw_w_drop", {axi.awvalid, axi.wvalid}, 0);
               check_val("bready", axi.bready, 1);
               axi.bvalid = (b_c >= b_d); b_c++;
               axi.bresp  = axi.bvalid ? resp : 2'($urandom);
               if (axi.bvalid && axi.bready) b_ok = 1;
            end
         end else begin
            idle_slave();
            check_val("rsp_valid", rsp_valid, 1);
            check_val("rsp_rdata", rsp_rdata, exp_rdata);
            check_val("rsp_err", rsp_err, exp_err);
            check_val("ready_quiet_in_rsp", {axi.rready, axi.bready}, 0);
            rsp_ready = (s_c >= rs_d); s_c++;
            if (rsp_valid && rsp_ready) done = 1;
         end
         @(negedge clk);
         cyc++;
      end
      rsp_ready = 1'b0;
      idle_slave();
      if (!done) begin
         check_val("txn_cycle_budget", 0, 1);
      end else begin
         check_val("rsp_drop", rsp_valid, 0);
         check_val("req_ready_back", req_ready, 1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      idle_slave();
      axi.rdata = '0; axi.rresp = '0; axi.bresp = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check_val("rst_req_ready", req_ready, 1);
      check_val("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, rsp_valid}, 0);
      check_val("rst_araddr", axi.araddr, 0);
      check_val("rst_awaddr", axi.awaddr, 0);
      check_val("rst_wdata", {axi.wdata, axi.wstrb}, 0);
      check_val("rst_rsp", {rsp_rdata, rsp_err}, 0);
      rst_n = 1'b1;

      // Zero-wait read
      run_txn(0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413, 2'b00, 0, 0, 0, 0, 0, 0);
      // Slow slave, slow core
      run_txn(0, 32'h8000_0004, 32'h0, 4'h0, 32'hA5A5_0F0F, 2'b00, 1, 3, 0, 0, 0, 3);
      // Skewed write
      run_txn(1, 32'h8000_0010, 32'hCAFE_BABE, 4'b0011, 32'h0, 2'b00, 0, 0, 2, 0, 0, 0);
      // W late, AW early; misaligned address and empty strobe pass through
      run_txn(1, 32'h8000_0013, 32'h0102_0304, 4'b0000, 32'h0, 2'b00, 0, 0, 0, 3, 2, 1);
      // Error responses
      run_txn(0, 32'h4000_0000, 32'h0, 4'h0, 32'h1234_5678, 2'b10, 0, 0, 0, 0, 0, 0);
      run_txn(1, 32'h4000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b11, 0, 0, 0, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 40; i++) begin
         logic [1:0] resp;
         resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, resp,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Reset while waiting for R
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0040; axi.arready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      axi.arready = 1'b0;
      check_val("rstmid_rready_pre", axi.rready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("rstmid_rready", axi.rready, 0);
      check_val("rstmid_arvalid", axi.arvalid, 0);
      check_val("rstmid_rsp_valid", rsp_valid, 0);
      check_val("rstmid_req_ready", req_ready, 1);
      rst_n = 1'b1;
      run_txn(0, 32'h8000_0044, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 0, 1, 0, 0, 0, 0);

      // Slave never accepts the read address
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h9000_0000; axi.arready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
`ifdef AXIL_MST_TIMEOUT_EN
      k = 0;
      while (!rsp_valid && k < 400) begin
         @(negedge clk);
         k++;
      end
      check_val("tmo_cycles", k, 255);
      check_val("tmo_rsp_err", rsp_err, 1);
      check_val("tmo_rsp_rdata", rsp_rdata, 0);
      check_val("tmo_arvalid", axi.arvalid, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_val("tmo_req_ready", req_ready, 1);
`else
      k = 0;
      repeat (1000) begin
         @(negedge clk);
         k++;
      end
      check_val("hold_arvalid", axi.arvalid, 1);
      check_val("hold_araddr", axi.araddr, 32'h9000_0000);
      check_val("hold_rsp_valid", rsp_valid, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("hold_rst_req_ready", req_ready, 1);
`endif
      run_txn(1, 32'h8000_0020, 32'h5555_AAAA, 4'hC, 32'h0, 2'b00, 0, 0, 0, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
